// File: rtl/ieeedrv_memmux_if.sv
// Shared memory port between the drive arbiter (master) and the memory (slave).
interface ieeedrv_memmux_if #(
    parameter int AW = 14,
    parameter int DW = 8,
    parameter int SW = 2
);
    logic [SW-1:0] mem_sel;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_q;

    modport master (
        output mem_sel,
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_q
    );

    modport slave (
        input  mem_sel,
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_q
    );
endinterface

// File: rtl/ieeedrv_memmux.sv
// Time-multiplexed shared-memory port for the drive CPUs. A phase strobe
// snapshots every requester; slots are then issued one per cycle on a single
// synchronous memory port and read data is held per requester until the next
// sequence.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for strobe; done cycle is spent here
// ISSUE  | slot slot_q is on the memory port
// DRAIN  | all slots issued; waiting LAT cycles for the last read data
module ieeedrv_memmux #(
    parameter int NREQ = 4,
    parameter int AW   = 14,
    parameter int DW   = 8,
    parameter int LAT  = 1,
    localparam int SW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                strobe,
    input  logic [NREQ-1:0]     drv_en,
    input  logic [AW-1:0]       drv_addr  [NREQ],
    input  logic [NREQ-1:0]     drv_we,
    input  logic [DW-1:0]       drv_wdata [NREQ],
    output logic [DW-1:0]       drv_data  [NREQ],
    ieeedrv_memmux_if.master    mem,
    output logic                busy,
    output logic                done,
    output logic                overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    drain_q, drain_d;

    logic [NREQ-1:0] en_l_q, en_l_d;
    logic [NREQ-1:0] we_l_q, we_l_d;
    logic [AW-1:0]   addr_l_q  [NREQ];
    logic [AW-1:0]   addr_l_d  [NREQ];
    logic [DW-1:0]   wdata_l_q [NREQ];
    logic [DW-1:0]   wdata_l_d [NREQ];

    logic [SW-1:0] mem_sel_q, mem_sel_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Stage 0 is loaded together with the port; stage LAT lines up with mem_q.
    logic [SW-1:0] dl_idx_q [LAT+1];
    logic [SW-1:0] dl_idx_d [LAT+1];
    logic [LAT:0]  dl_rd_q, dl_rd_d;

    logic [DW-1:0] drv_data_q [NREQ];
    logic [DW-1:0] drv_data_d [NREQ];
    logic          done_q, done_d;
    logic          overrun_q, overrun_d;

    // Next-state, port loading, read-data capture and overrun detection.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        drain_d     = drain_q;
        en_l_d      = en_l_q;
        we_l_d      = we_l_q;
        addr_l_d    = addr_l_q;
        wdata_l_d   = wdata_l_q;
        mem_sel_d   = mem_sel_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        drv_data_d  = drv_data_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q;

        dl_idx_d[0] = '0;
        dl_rd_d[0]  = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            dl_idx_d[i] = dl_idx_q[i-1];
            dl_rd_d[i]  = dl_rd_q[i-1];
        end

        for (int i = 0; i < NREQ; i++) begin
            if (dl_rd_q[LAT] && (dl_idx_q[LAT] == SW'(i))) begin
                drv_data_d[i] = mem.mem_q;
            end
        end

        if (strobe && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (strobe) begin
                    en_l_d      = drv_en;
                    we_l_d      = drv_we;
                    addr_l_d    = drv_addr;
                    wdata_l_d   = drv_wdata;
                    // Slot 0 goes straight from the inputs so it is on the port next cycle.
                    slot_d      = '0;
                    mem_sel_d   = '0;
                    mem_addr_d  = drv_addr[0];
                    mem_we_d    = drv_en[0] & drv_we[0];
                    mem_wdata_d = drv_wdata[0];
                    dl_rd_d[0]  = drv_en[0] & ~drv_we[0];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (slot_q == SW'(NREQ-1)) begin
                    drain_d = 2'(LAT-1);
                    state_d = S_DRAIN;
                end else begin
                    slot_d      = slot_q + 1'b1;
                    mem_sel_d   = slot_d;
                    dl_idx_d[0] = slot_d;
                    for (int i = 0; i < NREQ; i++) begin
                        if (SW'(i) == slot_d) begin
                            mem_addr_d  = addr_l_q[i];
                            mem_we_d    = en_l_q[i] & we_l_q[i];
                            mem_wdata_d = wdata_l_q[i];
                            dl_rd_d[0]  = en_l_q[i] & ~we_l_q[i];
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset flushes everything to zero.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            slot_q      <= '0;
            drain_q     <= '0;
            en_l_q      <= '0;
            we_l_q      <= '0;
            mem_sel_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            dl_rd_q     <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i <= LAT; i++) dl_idx_q[i] <= '0;
            for (int i = 0; i < NREQ; i++) begin
                addr_l_q[i]   <= '0;
                wdata_l_q[i]  <= '0;
                drv_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            drain_q     <= drain_d;
            en_l_q      <= en_l_d;
            we_l_q      <= we_l_d;
            addr_l_q    <= addr_l_d;
            wdata_l_q   <= wdata_l_d;
            mem_sel_q   <= mem_sel_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            dl_idx_q    <= dl_idx_d;
            dl_rd_q     <= dl_rd_d;
            drv_data_q  <= drv_data_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem.mem_sel   = mem_sel_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign drv_data      = drv_data_q;
    // The done cycle is already IDLE (a strobe there is accepted) but still reports busy.
    assign busy          = (state_q != S_IDLE) || done_q;
    assign done          = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_ieeedrv_memmux.sv
// Directed bench for ieeedrv_memmux: a 4-slot/LAT=1 instance on a writable
// memory, plus 1-slot and 8-slot LAT=3 instances on a read-only pattern memory.
module tb_ieeedrv_memmux;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_mis = 0;

    // ---------------- instance 0: NREQ=4, LAT=1 ----------------
    logic        st0;
    logic [3:0]  en0, we0;
    logic [13:0] addr0 [4];
    logic [7:0]  wd0 [4];
    logic [7:0]  dd0 [4];
    logic        busy0, done0, ov0;
    ieeedrv_memmux_if #(.AW(14), .DW(8), .SW(2)) if0 ();
    ieeedrv_memmux #(.NREQ(4), .AW(14), .DW(8), .LAT(1)) u0 (
        .clk_sys(clk_sys), .reset(reset), .strobe(st0), .drv_en(en0),
        .drv_addr(addr0), .drv_we(we0), .drv_wdata(wd0), .drv_data(dd0),
        .mem(if0), .busy(busy0), .done(done0), .overrun(ov0));

    logic [7:0] mem0 [16384];
    initial for (int a = 0; a < 16384; a++) mem0[a] = a[7:0];
    always @(posedge clk_sys) begin
        if0.mem_q <= mem0[if0.mem_addr];
        if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
    end

    // ---------------- instance 1: NREQ=1, LAT=3 ----------------
    logic        st1;
    logic [0:0]  en1, we1;
    logic [13:0] addr1 [1];
    logic [7:0]  wd1 [1];
    logic [7:0]  dd1 [1];
    logic        busy1, done1, ov1;
    ieeedrv_memmux_if #(.AW(14), .DW(8), .SW(1)) if1 ();
    ieeedrv_memmux #(.NREQ(1), .AW(14), .DW(8), .LAT(3)) u1 (
        .clk_sys(clk_sys), .reset(reset), .strobe(st1), .drv_en(en1),
        .drv_addr(addr1), .drv_we(we1), .drv_wdata(wd1), .drv_data(dd1),
        .mem(if1), .busy(busy1), .done(done1), .overrun(ov1));

    // ---------------- instance 2: NREQ=8, LAT=3 ----------------
    logic        st2;
    logic [7:0]  en2, we2;
    logic [13:0] addr2 [8];
    logic [7:0]  wd2 [8];
    logic [7:0]  dd2 [8];
    logic        busy2, done2, ov2;
    ieeedrv_memmux_if #(.AW(14), .DW(8), .SW(3)) if2 ();
    ieeedrv_memmux #(.NREQ(8), .AW(14), .DW(8), .LAT(3)) u2 (
        .clk_sys(clk_sys), .reset(reset), .strobe(st2), .drv_en(en2),
        .drv_addr(addr2), .drv_we(we2), .drv_wdata(wd2), .drv_data(dd2),
        .mem(if2), .busy(busy2), .done(done2), .overrun(ov2));

    // Read-only pattern memories, data = addr[7:0] ^ 0x5A, three-cycle latency.
    logic [7:0] p1a, p1b, p2a, p2b;
    always @(posedge clk_sys) begin
        p1a <= if1.mem_addr[7:0] ^ 8'h5A;
        p1b <= p1a;
        if1.mem_q <= p1b;
        p2a <= if2.mem_addr[7:0] ^ 8'h5A;
        p2b <= p2a;
        if2.mem_q <= p2b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_sys);
    endtask

    // One full sequence on instance 0; checks port/done/busy timing cycle by cycle.
    task automatic seq0(input string tag, input logic [3:0] en, input logic [3:0] we,
                        input logic [3:0][13:0] a, input logic [3:0][7:0] wd);
        en0 = en; we0 = we;
        for (int i = 0; i < 4; i++) begin addr0[i] = a[i]; wd0[i] = wd[i]; end
        st0 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            if (c == 1) begin
                // latched copies only: scramble live inputs
                st0 = 1'b0; en0 = ~en; we0 = ~we;
                for (int i = 0; i < 4; i++) begin addr0[i] = 14'h3FFF; wd0[i] = 8'hEE; end
            end
            if (c <= 4) begin
                chk($sformatf("%s_sel_c%0d", tag, c), if0.mem_sel, c - 1);
                chk($sformatf("%s_addr_c%0d", tag, c), if0.mem_addr, a[c-1]);
                chk($sformatf("%s_we_c%0d", tag, c), if0.mem_we, en[c-1] & we[c-1]);
                if (en[c-1] & we[c-1]) chk($sformatf("%s_wd_c%0d", tag, c), if0.mem_wdata, wd[c-1]);
            end else begin
                chk($sformatf("%s_we_c%0d", tag, c), if0.mem_we, 1'b0);
            end
            chk($sformatf("%s_done_c%0d", tag, c), done0, c == 6);
            chk($sformatf("%s_busy_c%0d", tag, c), busy0, c <= 6);
        end
    endtask

    initial begin
        reset = 1'b1;
        st0 = 0; en0 = 0; we0 = 0;
        st1 = 0; en1 = 0; we1 = 0;
        st2 = 0; en2 = 0; we2 = 0;
        for (int i = 0; i < 4; i++) begin addr0[i] = 0; wd0[i] = 0; end
        addr1[0] = 0; wd1[0] = 0;
        for (int i = 0; i < 8; i++) begin addr2[i] = 0; wd2[i] = 0; end
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        // Reset state
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk("rst_ovr", ov0, 1'b0);
        chk("rst_sel", if0.mem_sel, 2'd0);
        chk("rst_we", if0.mem_we, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("rst_d%0d", i), dd0[i], 8'h00);

        // All-enabled reads
        seq0("rd", 4'hF, 4'h0, {14'h43, 14'h32, 14'h21, 14'h10}, '0);
        chk("rd_d0", dd0[0], 8'h10);
        chk("rd_d1", dd0[1], 8'h21);
        chk("rd_d2", dd0[2], 8'h32);
        chk("rd_d3", dd0[3], 8'h43);

        // Writes in slots 1 and 3: drv_data of those slots must not move
        seq0("wr", 4'hF, 4'b1010, {14'h44, 14'h60, 14'h21, 14'h50},
             {8'h99, 8'h00, 8'hA5, 8'h00});
        chk("wr_d0", dd0[0], 8'h50);
        chk("wr_d1", dd0[1], 8'h21);
        chk("wr_d2", dd0[2], 8'h60);
        chk("wr_d3", dd0[3], 8'h43);

        // Read back the written locations
        seq0("rb", 4'hF, 4'h0, {14'h10, 14'h10, 14'h44, 14'h21}, '0);
        chk("rb_d0", dd0[0], 8'hA5);
        chk("rb_d1", dd0[1], 8'h99);
        chk("rb_d2", dd0[2], 8'h10);

        // Disabled slot 2 (with a write request that must be gated off)
        seq0("en", 4'b1011, 4'b0100, {14'h04, 14'h03, 14'h02, 14'h01}, {8'h00, 8'h77, 8'h00, 8'h00});
        chk("en_d0", dd0[0], 8'h01);
        chk("en_d1", dd0[1], 8'h02);
        chk("en_d2", dd0[2], 8'h10);
        chk("en_d3", dd0[3], 8'h04);
        chk("en_mem3", mem0[3], 8'h03);

        // Strobe at t0+3 while busy: overrun, first sequence unaffected
        en0 = 4'hF; we0 = 4'h0;
        addr0[0] = 14'h11; addr0[1] = 14'h12; addr0[2] = 14'h13; addr0[3] = 14'h14;
        st0 = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc();
            st0 = 1'b0;
            if (c == 3) begin
                chk("ov_pre", ov0, 1'b0);
                for (int i = 0; i < 4; i++) addr0[i] = 14'h70;
                st0 = 1'b1;
            end
            if (c >= 4) chk($sformatf("ov_c%0d", c), ov0, 1'b1);
            chk($sformatf("ov_done_c%0d", c), done0, c == 6);
            chk($sformatf("ov_busy_c%0d", c), busy0, c <= 6);
        end
        chk("ov_d0", dd0[0], 8'h11);
        chk("ov_d1", dd0[1], 8'h12);
        chk("ov_d2", dd0[2], 8'h13);
        chk("ov_d3", dd0[3], 8'h14);

        // Reset at t0+2 aborts; coincident strobe is ignored
        st0 = 1'b1;
        cyc(); st0 = 1'b0;
        cyc(); reset = 1'b1; st0 = 1'b1;
        cyc(); reset = 1'b0; st0 = 1'b0;
        chk("ra_busy", busy0, 1'b0);
        chk("ra_ovr", ov0, 1'b0);
        chk("ra_we", if0.mem_we, 1'b0);
        for (int i = 0; i < 4; i++) chk($sformatf("ra_d%0d", i), dd0[i], 8'h00);
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk($sformatf("ra_done_%0d", c), done0, 1'b0);
            chk($sformatf("ra_idle_%0d", c), busy0, 1'b0);
        end
        seq0("pr", 4'hF, 4'h0, {14'h43, 14'h32, 14'h21, 14'hA5}, '0);
        chk("pr_d0", dd0[0], 8'hA5);
        chk("pr_d3", dd0[3], 8'h43);

        // NREQ=1, LAT=3: done at t0+5, back-to-back strobe at period 5
        en1 = 1'b1; we1 = 1'b0; addr1[0] = 14'h33; st1 = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            st1 = 1'b0;
            if (c == 1) addr1[0] = 14'h3FFF;
            if (c == 5) begin
                chk("n1_d0_a", dd1[0], 8'h69);
                addr1[0] = 14'h07; st1 = 1'b1;
            end
            if (c == 4) chk("n1_d0_pre", dd1[0], 8'h00);
            chk($sformatf("n1_done_c%0d", c), done1, (c == 5) || (c == 10));
            chk($sformatf("n1_busy_c%0d", c), busy1, c <= 10);
        end
        chk("n1_d0_b", dd1[0], 8'h5D);
        chk("n1_ovr", ov1, 1'b0);

        // NREQ=8, LAT=3: done at t0+12, back-to-back strobe at period 12
        en2 = 8'hFF; we2 = 8'h00;
        for (int i = 0; i < 8; i++) addr2[i] = 14'h20 + 14'(i);
        st2 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            st2 = 1'b0;
            if (c <= 8) chk($sformatf("n8_sel_c%0d", c), if2.mem_sel, c - 1);
            if (c == 5) chk("n8_d0_edge", dd2[0], 8'h20 ^ 8'h5A);
            if (c == 11) chk("n8_d7_pre", dd2[7], 8'h00);
            if (c == 12) begin
                for (int i = 0; i < 8; i++)
                    chk($sformatf("n8_a_d%0d", i), dd2[i], (8'h20 + 8'(i)) ^ 8'h5A);
                for (int i = 0; i < 8; i++) addr2[i] = 14'h40 + 14'(i);
                st2 = 1'b1;
            end
            chk($sformatf("n8_done_c%0d", c), done2, (c == 12) || (c == 24));
            chk($sformatf("n8_busy_c%0d", c), busy2, c <= 24);
        end
        for (int i = 0; i < 8; i++)
            chk($sformatf("n8_b_d%0d", i), dd2[i], (8'h40 + 8'(i)) ^ 8'h5A);
        chk("n8_ovr", ov2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
